i2c_fifo: RTL and testbench
===========================

# i2c_fifo

Synchronous first-word-fall-through FIFO between the APB front end and the I2C protocol engine. One instance buffers the TX path (written by the APB `WR_ENA`/`WRITE_DATA_ON_TX`, drained by the I2C engine, `EMPTY` drives `TX_EMPTY`). A second instance buffers the RX path (filled by the I2C engine, popped by the APB `RD_ENA`, `DATA_OUT` drives `READ_DATA_ON_RX`, `EMPTY` drives `RX_EMPTY`). Sticky overflow/underflow flags feed the APB `ERROR` input.

## Interface
Parameters:
- `DWIDTH`, 32, data word width.
- `DEPTH`, 16, number of entries; must be a power of two and ≥ 2.
- `AFULL_LVL`, `DEPTH-2`, occupancy at or above which `ALMOST_FULL` asserts.

Ports:
- `PCLK` in 1: single clock; all state updates on the rising edge.
- `PRESETn` in 1: reset, asynchronous, active-low.
- `WR_EN` in 1: push `DATA_IN` at this edge.
- `DATA_IN` in DWIDTH: write data.
- `RD_EN` in 1: pop the head entry at this edge.
- `DATA_OUT` out DWIDTH: current head entry (fall-through); 0 when `EMPTY`.
- `EMPTY` out 1: occupancy == 0.
- `FULL` out 1: occupancy == DEPTH.
- `ALMOST_FULL` out 1: occupancy ≥ `AFULL_LVL`.
- `LEVEL` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `ERR_CLR` in 1: clears the sticky error flags.
- `OVERFLOW` out 1: sticky; a write was attempted while full and not simultaneously popped.
- `UNDERFLOW` out 1: sticky; a read was attempted while empty.
- `ERROR` out 1: `OVERFLOW | UNDERFLOW`.

## Operation
- **Pointers.** Write and read pointers are $clog2(DEPTH)+1 bits. The MSB is the wrap bit; the low bits index storage.
  - `EMPTY` when the pointers are equal.
  - `FULL` when the low bits are equal and the MSBs differ.
  - `LEVEL = wr_ptr - rd_ptr`, modulo 2^(ADDR_W+1).
  - Both pointers wrap naturally from DEPTH-1 to 0 in the index bits.
- **Accepted write.** `WR_EN` with `!FULL`, or `WR_EN` with `FULL` and an accepted read in the same cycle. Stores `DATA_IN` at `wr_ptr`; `wr_ptr` increments.
- **Accepted read.** `RD_EN` with `!EMPTY`. `rd_ptr` increments. The popped word is the `DATA_OUT` value present during that cycle.
- **Simultaneous read and write:**
  - Not empty, not full: both accepted, `LEVEL` unchanged.
  - Full: both accepted, `LEVEL` stays DEPTH, no overflow.
  - Empty: write accepted, read rejected, `UNDERFLOW` set, `LEVEL` becomes 1.
- **Rejected accesses:**
  - A rejected write leaves storage and pointers untouched and sets `OVERFLOW`.
  - A rejected read leaves the pointers untouched and sets `UNDERFLOW`.
- **Error flags.**
  - `ERR_CLR` clears both flags at the edge.
  - If `ERR_CLR` and a new error event coincide, the flag ends set: set wins.
- **Status outputs.** `DATA_OUT`, `EMPTY`, `FULL`, `ALMOST_FULL`, `LEVEL` and `ERROR` are all derived combinationally from registered state. No input reaches an output combinationally.
- **Reset.**
  - Pointers are 0 and error flags are 0.
  - Output values: `EMPTY`=1, `FULL`=0, `ALMOST_FULL`=0, `LEVEL`=0, `DATA_OUT`=0, `ERROR`=0.
  - Storage is not reset.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock.

## Timing
- **Write-to-read latency.** A word written at edge N is visible on `DATA_OUT` and `EMPTY` deasserts after edge N. The word can be popped at edge N+1.
- **APB compatibility.** The APB access phase drives `RD_EN` for exactly one cycle with `PREADY`=1. `DATA_OUT` must therefore be valid combinationally in that same cycle; the fall-through structure guarantees this.
- **Flag update.** `FULL`, `LEVEL`, `ALMOST_FULL` and error flags update one edge after the causing access.
- **Throughput.** One push and one pop per cycle sustained, with no bubbles.

## Structure
- **Package `i2c_fifo_pkg`.** Holds `I2C_FIFO_DWIDTH`=32, `I2C_FIFO_DEPTH`=16, and the `I2C_FIFO_AW` constant derived from depth.
- **Sub-module `i2c_fifo_mem`.**
  - DEPTH×DWIDTH register array.
  - One write port: `we`, `waddr`, `wdata`.
  - One asynchronous read port: `raddr`, `rdata`.
  - No reset.
- **Top level.** Pointers, flag logic and error flags live in `i2c_fifo`.

## Test plan
- **Reset state.** Assert `PRESETn`=0 mid-stream with 5 entries held → outputs go immediately to `EMPTY`=1, `LEVEL`=0, `DATA_OUT`=0, `ERROR`=0.
- **Fill and drain.** Write 0x00000001..0x00000010 (DEPTH=16):
  - `ALMOST_FULL` rises after the 14th write; `FULL` rises after the 16th.
  - A 17th write sets `OVERFLOW` and leaves `LEVEL`=16.
  - 16 reads return 1..16 in order, then `EMPTY`=1.
- **Read on empty.** `RD_EN` while empty → `UNDERFLOW`=1, `ERROR`=1, `LEVEL` stays 0. `ERR_CLR` clears both at the next edge.
- **Simultaneous access:**
  - Full with `RD_EN`+`WR_EN`(0xA5A5A5A5) → head popped, `LEVEL`=16, no overflow, 0xA5A5A5A5 emerges 16 pops later.
  - Empty with both asserted → `LEVEL`=1, `UNDERFLOW`=1.
- **Wrap-around.** 40 cycles of continuous write+read at `LEVEL`=3 → output sequence matches the input delayed by 3 entries across pointer wrap.
- **APB integration.** APB write to address 0 with 0xDEADBEEF, then APB read at address 4 (RX instance preloaded with 0x12345678) → TX FIFO head = 0xDEADBEEF; `PRDATA`=0x12345678 in the access cycle; RX `LEVEL` decrements by 1.

Source files
------------

// File: rtl/i2c_fifo_pkg.sv
// Shared sizing constants for the I2C TX/RX first-word-fall-through FIFOs.
package i2c_fifo_pkg;

    localparam int I2C_FIFO_DWIDTH = 32;
    localparam int I2C_FIFO_DEPTH  = 16;
    localparam int I2C_FIFO_AW     = $clog2(I2C_FIFO_DEPTH);

endpackage

// File: rtl/i2c_fifo_if.sv
// Push/pop/status bundle between a FIFO user (master) and the FIFO itself (slave).
interface i2c_fifo_if
    import i2c_fifo_pkg::*;
#(
    parameter int DWIDTH = I2C_FIFO_DWIDTH,
    parameter int DEPTH  = I2C_FIFO_DEPTH
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              WR_EN;
    logic [DWIDTH-1:0] DATA_IN;
    logic              RD_EN;
    logic [DWIDTH-1:0] DATA_OUT;
    logic              EMPTY;
    logic              FULL;
    logic              ALMOST_FULL;
    logic [LW-1:0]     LEVEL;
    logic              ERR_CLR;
    logic              OVERFLOW;
    logic              UNDERFLOW;
    logic              ERROR;

    modport master (
        output WR_EN, DATA_IN, RD_EN, ERR_CLR,
        input  DATA_OUT, EMPTY, FULL, ALMOST_FULL, LEVEL, OVERFLOW, UNDERFLOW, ERROR
    );

    modport slave (
        input  WR_EN, DATA_IN, RD_EN, ERR_CLR,
        output DATA_OUT, EMPTY, FULL, ALMOST_FULL, LEVEL, OVERFLOW, UNDERFLOW, ERROR
    );

endinterface

// File: rtl/i2c_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read port so the head word falls through without a clock.
module i2c_fifo_mem
    import i2c_fifo_pkg::*;
#(
    parameter int DWIDTH = I2C_FIFO_DWIDTH,
    parameter int DEPTH  = I2C_FIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              PCLK,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge PCLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers, occupancy/status flags
// and sticky overflow/underflow errors; one push and one pop per cycle.
module i2c_fifo
    import i2c_fifo_pkg::*;
#(
    parameter int DWIDTH    = I2C_FIFO_DWIDTH,
    parameter int DEPTH     = I2C_FIFO_DEPTH,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic      PCLK,
    input  logic      PRESETn,
    i2c_fifo_if.slave bus
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] AFULL_V = (AW+1)'(AFULL_LVL);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       level;
    logic              empty;
    logic              full;
    logic              wr_acc;
    logic              rd_acc;
    logic              overflow_q;
    logic              underflow_q;
    logic [DWIDTH-1:0] rdata;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level  = wr_ptr - rd_ptr;

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign rd_acc = bus.RD_EN && !empty;
    assign wr_acc = bus.WR_EN && (!full || rd_acc);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // A new error event in the clearing cycle keeps the flag set.
            overflow_q  <= (overflow_q  && !bus.ERR_CLR) || (bus.WR_EN && !wr_acc);
            underflow_q <= (underflow_q && !bus.ERR_CLR) || (bus.RD_EN && empty);
        end
    end

    i2c_fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .PCLK   (PCLK),
        .we     (wr_acc),
        .waddr  (wr_ptr[AW-1:0]),
        .wdata  (bus.DATA_IN),
        .raddr  (rd_ptr[AW-1:0]),
        .rdata  (rdata)
    );

    assign bus.DATA_OUT    = empty ? '0 : rdata;
    assign bus.EMPTY       = empty;
    assign bus.FULL        = full;
    assign bus.ALMOST_FULL = (level >= AFULL_V);
    assign bus.LEVEL       = level;
    assign bus.OVERFLOW    = overflow_q;
    assign bus.UNDERFLOW   = underflow_q;
    assign bus.ERROR       = overflow_q | underflow_q;

endmodule

// File: tb/tb_i2c_fifo.sv
// Bench for i2c_fifo: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations and a small APB-style hookup.
module tb_i2c_fifo;

    localparam int DW = 32;
    localparam int DP = 16;

    logic PCLK;
    logic PRESETn;

    i2c_fifo_if #(.DWIDTH(DW), .DEPTH(DP)) tx_if ();
    i2c_fifo_if #(.DWIDTH(DW), .DEPTH(DP)) rx_if ();

    i2c_fifo #(.DWIDTH(DW), .DEPTH(DP), .AFULL_LVL(DP-2)) u_tx (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (tx_if.slave)
    );

    i2c_fifo #(.DWIDTH(DW), .DEPTH(DP), .AFULL_LVL(DP-2)) u_rx (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (rx_if.slave)
    );

    logic          drv_wr, drv_rd, drv_clr;
    logic [DW-1:0] drv_din;
    logic          psel, penable, pwrite;
    logic [31:0]   paddr, pwdata;
    logic          apb_tx_wr, apb_rx_rd;
    logic [31:0]   prdata;
    logic          rx_wr;
    logic [DW-1:0] rx_din;

    assign apb_tx_wr = psel && penable && pwrite && (paddr == 32'd0);
    assign apb_rx_rd = psel && penable && !pwrite && (paddr == 32'd4);
    assign prdata    = rx_if.DATA_OUT;

    assign tx_if.WR_EN   = drv_wr | apb_tx_wr;
    assign tx_if.DATA_IN = apb_tx_wr ? pwdata : drv_din;
    assign tx_if.RD_EN   = drv_rd;
    assign tx_if.ERR_CLR = drv_clr;

    assign rx_if.WR_EN   = rx_wr;
    assign rx_if.DATA_IN = rx_din;
    assign rx_if.RD_EN   = apb_rx_rd;
    assign rx_if.ERR_CLR = 1'b0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_chk  = 0;
    int n_fail = 0;
    bit check_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the TX instance: a queue plus two sticky bits.
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_udf;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            bit rd_ok, wr_ok, ovf_ev, udf_ev;
            rd_ok  = tx_if.RD_EN && (mq.size() > 0);
            wr_ok  = tx_if.WR_EN && ((mq.size() < DP) || rd_ok);
            ovf_ev = tx_if.WR_EN && !wr_ok;
            udf_ev = tx_if.RD_EN && (mq.size() == 0);
            if (rd_ok) void'(mq.pop_front());
            if (wr_ok) mq.push_back(tx_if.DATA_IN);
            m_ovf = (m_ovf && !tx_if.ERR_CLR) || ovf_ev;
            m_udf = (m_udf && !tx_if.ERR_CLR) || udf_ev;
        end
    end

    always @(negedge PCLK) begin
        if (check_en) begin
            int sz;
            sz = mq.size();
            chk("m_data_out",  tx_if.DATA_OUT,    (sz > 0) ? {32'd0, mq[0]} : 64'd0);
            chk("m_empty",     tx_if.EMPTY,       (sz == 0) ? 64'd1 : 64'd0);
            chk("m_full",      tx_if.FULL,        (sz == DP) ? 64'd1 : 64'd0);
            chk("m_afull",     tx_if.ALMOST_FULL, (sz >= DP-2) ? 64'd1 : 64'd0);
            chk("m_level",     tx_if.LEVEL,       64'(sz));
            chk("m_overflow",  tx_if.OVERFLOW,    64'(m_ovf));
            chk("m_underflow", tx_if.UNDERFLOW,   64'(m_udf));
            chk("m_error",     tx_if.ERROR,       64'(m_ovf | m_udf));
        end
    end

    task automatic cyc(input logic wr, input logic [DW-1:0] din, input logic rd, input logic clr);
        drv_wr  = wr;
        drv_din = din;
        drv_rd  = rd;
        drv_clr = clr;
        @(negedge PCLK);
        drv_wr  = 1'b0;
        drv_rd  = 1'b0;
        drv_clr = 1'b0;
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(negedge PCLK);
        penable = 1'b1;
        #1 rdata = prdata;
        @(negedge PCLK);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd_word;
        logic [31:0] exp_w;

        drv_wr = 0; drv_rd = 0; drv_clr = 0; drv_din = '0;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        rx_wr = 0; rx_din = '0;
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_empty",   tx_if.EMPTY, 1);
        chk("rst_level",   tx_if.LEVEL, 0);
        chk("rst_dout",    tx_if.DATA_OUT, 0);
        chk("rst_error",   tx_if.ERROR, 0);
        chk("rst_full",    tx_if.FULL, 0);
        chk("rst_afull",   tx_if.ALMOST_FULL, 0);
        PRESETn  = 1'b1;
        check_en = 1;

        // Read on empty, then clear.
        cyc(0, '0, 1, 0);
        chk("udf_set",   tx_if.UNDERFLOW, 1);
        chk("udf_error", tx_if.ERROR, 1);
        chk("udf_level", tx_if.LEVEL, 0);
        cyc(0, '0, 0, 1);
        chk("clr_udf",   tx_if.UNDERFLOW, 0);
        chk("clr_error", tx_if.ERROR, 0);

        // Async reset with 5 entries held and an error pending.
        cyc(0, '0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 32'h50 + 32'(i), 0, 0);
        chk("pre_rst_level", tx_if.LEVEL, 5);
        chk("pre_rst_error", tx_if.ERROR, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_empty", tx_if.EMPTY, 1);
        chk("arst_level", tx_if.LEVEL, 0);
        chk("arst_dout",  tx_if.DATA_OUT, 0);
        chk("arst_error", tx_if.ERROR, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Fill 1..16, watching the threshold flags.
        for (int i = 1; i <= DP; i++) begin
            cyc(1, 32'(i), 0, 0);
            if (i == 13) chk("afull_13", tx_if.ALMOST_FULL, 0);
            if (i == 14) chk("afull_14", tx_if.ALMOST_FULL, 1);
            if (i == 15) chk("full_15",  tx_if.FULL, 0);
            if (i == 16) chk("full_16",  tx_if.FULL, 1);
        end
        cyc(1, 32'h11, 0, 0);
        chk("ovf_set",   tx_if.OVERFLOW, 1);
        chk("ovf_level", tx_if.LEVEL, 16);
        cyc(0, '0, 0, 1);
        for (int i = 1; i <= DP; i++) begin
            chk("drain_data", tx_if.DATA_OUT, 64'(i));
            cyc(0, '0, 1, 0);
        end
        chk("drain_empty", tx_if.EMPTY, 1);

        // Simultaneous push/pop while full.
        for (int i = 1; i <= DP; i++) cyc(1, 32'h100 + 32'(i), 0, 0);
        chk("sim_full_head", tx_if.DATA_OUT, 32'h101);
        cyc(1, 32'hA5A5A5A5, 1, 0);
        chk("sim_full_level", tx_if.LEVEL, 16);
        chk("sim_full_ovf",   tx_if.OVERFLOW, 0);
        for (int i = 0; i < DP; i++) begin
            exp_w = (i < DP-1) ? 32'h102 + 32'(i) : 32'hA5A5A5A5;
            chk("sim_full_drain", tx_if.DATA_OUT, exp_w);
            cyc(0, '0, 1, 0);
        end

        // Simultaneous push/pop while empty.
        cyc(1, 32'h77, 1, 0);
        chk("sim_empty_level", tx_if.LEVEL, 1);
        chk("sim_empty_udf",   tx_if.UNDERFLOW, 1);
        chk("sim_empty_head",  tx_if.DATA_OUT, 32'h77);
        cyc(0, '0, 1, 1);
        chk("sim_empty_clr", tx_if.ERROR, 0);

        // Continuous streaming at level 3 across several pointer wraps.
        for (int i = 0; i < 3; i++) cyc(1, 32'h200 + 32'(i), 0, 0);
        for (int i = 0; i < 40; i++) begin
            exp_w = (i < 3) ? 32'h200 + 32'(i) : 32'h300 + 32'(i - 3);
            chk("wrap_data", tx_if.DATA_OUT, exp_w);
            cyc(1, 32'h300 + 32'(i), 1, 0);
        end
        chk("wrap_level", tx_if.LEVEL, 3);
        for (int i = 37; i < 40; i++) begin
            chk("wrap_tail", tx_if.DATA_OUT, 32'h300 + 32'(i));
            cyc(0, '0, 1, 0);
        end

        // APB-style hookup: write TX at 0x0, read RX at 0x4.
        apb_xfer(1'b1, 32'd0, 32'hDEADBEEF, rd_word);
        chk("apb_tx_head",  tx_if.DATA_OUT, 32'hDEADBEEF);
        chk("apb_tx_level", tx_if.LEVEL, 1);
        rx_wr = 1'b1; rx_din = 32'h12345678;
        @(negedge PCLK);
        rx_din = 32'h0BADF00D;
        @(negedge PCLK);
        rx_wr = 1'b0;
        chk("apb_rx_pre_level", rx_if.LEVEL, 2);
        apb_xfer(1'b0, 32'd4, 32'd0, rd_word);
        chk("apb_prdata",       rd_word, 32'h12345678);
        chk("apb_rx_level",     rx_if.LEVEL, 1);
        chk("apb_rx_next_head", rx_if.DATA_OUT, 32'h0BADF00D);
        cyc(0, '0, 1, 0);
        chk("end_empty", tx_if.EMPTY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
